// File: rtl/spi_master_controller.sv
// ==== spi_master_controller : SPI mode-0, LSB-first, 8-bit full-duplex master ====
// ==== rev 1.0                                                                 ====
`default_nettype none

module spi_master_controller #(
  parameter int CLK_DIV = 2
) (
  input  logic       CLK,
  input  logic       CLR_N,
  input  logic       START,
  input  logic [7:0] TX_DATA,
  input  logic       MISO,
  output logic       SCLK,
  output logic       CS_N,
  output logic       MOSI,
  output logic       BUSY,
  output logic       DONE,
  output logic [7:0] RX_DATA
);

  localparam logic [7:0] c_div_last = 8'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_SHI   = 3'd2,
    S_SLO   = 3'd3,
    S_HOLD  = 3'd4,
    S_FIN   = 3'd5
  } state_t;

  state_t     r_state;
  logic [7:0] r_tx;
  logic [7:0] r_rx;
  logic [7:0] r_div;
  logic [3:0] r_bit;
  logic       w_div_end;

  assign w_div_end = (r_div == c_div_last);

  always_ff @(posedge CLK or negedge CLR_N) begin
    if (!CLR_N) begin
      r_state <= S_IDLE;
      r_tx    <= 8'h00;
      r_rx    <= 8'h00;
      r_div   <= 8'h00;
      r_bit   <= 4'd0;
      SCLK    <= 1'b0;
      CS_N    <= 1'b1;
      MOSI    <= 1'b0;
      BUSY    <= 1'b0;
      DONE    <= 1'b0;
      RX_DATA <= 8'h00;
    end else begin
      DONE <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (START) begin
            // bit 0 goes straight onto MOSI; the rest waits in the shifter
            r_tx    <= {1'b0, TX_DATA[7:1]};
            r_rx    <= 8'h00;
            r_div   <= 8'h00;
            r_bit   <= 4'd0;
            CS_N    <= 1'b0;
            MOSI    <= TX_DATA[0];
            BUSY    <= 1'b1;
            r_state <= S_SETUP;
          end
        end
        S_SETUP: begin
          if (w_div_end) begin
            r_div          <= 8'h00;
            SCLK           <= 1'b1;
            r_rx[r_bit[2:0]] <= MISO;
            r_state        <= S_SHI;
          end else begin
            r_div <= r_div + 8'd1;
          end
        end
        S_SHI: begin
          if (w_div_end) begin
            r_div   <= 8'h00;
            SCLK    <= 1'b0;
            r_bit   <= r_bit + 4'd1;
            MOSI    <= r_tx[0];
            r_tx    <= {1'b0, r_tx[7:1]};
            r_state <= S_SLO;
          end else begin
            r_div <= r_div + 8'd1;
          end
        end
        S_SLO: begin
          // every high phase, the eighth included, is followed by a full low phase
          if (w_div_end) begin
            r_div <= 8'h00;
            if (r_bit == 4'd8) begin
              r_state <= S_HOLD;
            end else begin
              SCLK             <= 1'b1;
              r_rx[r_bit[2:0]] <= MISO;
              r_state          <= S_SHI;
            end
          end else begin
            r_div <= r_div + 8'd1;
          end
        end
        S_HOLD: begin
          if (w_div_end) begin
            r_div   <= 8'h00;
            CS_N    <= 1'b1;
            MOSI    <= 1'b0;
            BUSY    <= 1'b0;
            DONE    <= 1'b1;
            RX_DATA <= r_rx;
            r_state <= S_FIN;
          end else begin
            r_div <= r_div + 8'd1;
          end
        end
        S_FIN: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_spi_master_controller.sv
// ==== tb_spi_master_controller : waveform/data checks of the SPI master at CLK_DIV=2 and 1 ====
// ==== rev 1.0                                                                              ====
`default_nettype none

module tb_spi_master_controller;

  logic       CLK;
  logic       CLR_N;
  logic       START1, START2;
  logic [7:0] TX_DATA;
  logic       MISO1, MISO2;
  logic       SCLK1, CS_N1, MOSI1, BUSY1, DONE1;
  logic       SCLK2, CS_N2, MOSI2, BUSY2, DONE2;
  logic [7:0] RX1, RX2;

  bit          lb;
  logic [7:0]  patr;
  logic [3:0]  pidx = 4'd0;
  int unsigned cyc = 0;
  int unsigned done_cyc;
  int          nchk = 0;
  int          nerr = 0;
  logic [7:0]  last_rx [1:2];

  typedef struct {
    int         d;
    logic [7:0] tx;
    bit         loop;
    logic [7:0] pat;
    logic [7:0] exp_rx;
  } vec_t;
  vec_t vecs [5];

  spi_master_controller #(.CLK_DIV(2)) dut2 (
    .CLK(CLK), .CLR_N(CLR_N), .START(START2), .TX_DATA(TX_DATA), .MISO(MISO2),
    .SCLK(SCLK2), .CS_N(CS_N2), .MOSI(MOSI2), .BUSY(BUSY2), .DONE(DONE2), .RX_DATA(RX2)
  );

  spi_master_controller #(.CLK_DIV(1)) dut1 (
    .CLK(CLK), .CLR_N(CLR_N), .START(START1), .TX_DATA(TX_DATA), .MISO(MISO1),
    .SCLK(SCLK1), .CS_N(CS_N1), .MOSI(MOSI1), .BUSY(BUSY1), .DONE(DONE1), .RX_DATA(RX1)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  // Mode-0 slave: presents bit i from frame start / SCLK fall i until the next rise
  always @(negedge SCLK2 or posedge CS_N2) begin
    if (CS_N2) pidx <= 4'd0;
    else       pidx <= pidx + 4'd1;
  end

  assign MISO2 = lb ? MOSI2 : patr[pidx[2:0]];
  assign MISO1 = MOSI1;

  function automatic logic [7:0] model_rx(input logic [7:0] tx, input bit loop, input logic [7:0] pat);
    return loop ? tx : pat;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic smp(input int d, output logic [4:0] v, output logic [7:0] rx);
    if (d == 1) begin
      v  = {SCLK1, CS_N1, MOSI1, BUSY1, DONE1};
      rx = RX1;
    end else begin
      v  = {SCLK2, CS_N2, MOSI2, BUSY2, DONE2};
      rx = RX2;
    end
  endtask

  task automatic idle_check(input int k, input int d);
    logic [4:0] v;
    logic [7:0] rx;
    repeat (k) begin
      @(negedge CLK);
      smp(d, v, rx);
      chk("idle_outputs", 32'(v), 32'(5'b01000));
      chk("idle_rx_hold", 32'(rx), 32'(last_rx[d]));
    end
  endtask

  // Frame n counts the cycles after the accepting edge; phase p = (n-1)/d walks
  // setup, 8 x (high, low), hold, then the DONE cycle.
  task automatic run_frame(input int d, input logic [7:0] tx, input bit loop,
                           input logic [7:0] pat, input logic [7:0] exp_rx,
                           input int restart_at, input bit hold_start);
    logic [4:0] v;
    logic [7:0] rx;
    int         p;
    logic       e_sclk;
    TX_DATA = tx;
    lb      = loop;
    patr    = pat;
    if (d == 1) START1 = 1'b1; else START2 = 1'b1;
    if (hold_start) begin
      @(negedge CLK);
      smp(d, v, rx);
      chk("gap_outputs", 32'(v), 32'(5'b01000));
    end
    for (int n = 1; n <= 18 * d + 1; n++) begin
      @(negedge CLK);
      if (n == 1) begin
        START1  = 1'b0;
        START2  = 1'b0;
        TX_DATA = 8'($urandom);
      end
      if (restart_at != 0 && n == restart_at) begin
        START2  = 1'b1;
        TX_DATA = 8'h3C;
      end
      if (restart_at != 0 && n == restart_at + 1) START2 = 1'b0;
      smp(d, v, rx);
      if (n <= 18 * d) begin
        p      = (n - 1) / d;
        e_sclk = (p % 2 == 1) && (p < 16);
        chk("frame_sclk_cs_busy_done", 32'({v[4], v[3], v[1], v[0]}), 32'({e_sclk, 1'b0, 1'b1, 1'b0}));
        if (p < 16)        chk("mosi_bit", 32'(v[2]), 32'(tx[p / 2]));
        else if (tx == 0)  chk("mosi_zero", 32'(v[2]), 32'(1'b0));
        if (n == 18 * d)   chk("rx_hold_in_frame", 32'(rx), 32'(last_rx[d]));
      end else begin
        chk("done_cycle_outputs", 32'(v), 32'(5'b01001));
        chk("rx_data", 32'(rx), 32'(exp_rx));
        last_rx[d] = exp_rx;
        done_cyc   = cyc;
      end
    end
  endtask

  initial begin
    logic [4:0]  v;
    logic [7:0]  rx;
    int unsigned t1;
    int          rd;
    logic [7:0]  rtx, rpat;
    bit          rloop;

    vecs[0] = '{d: 2, tx: 8'hA5, loop: 1'b1, pat: 8'h00, exp_rx: 8'hA5};
    vecs[1] = '{d: 2, tx: 8'h00, loop: 1'b0, pat: 8'hFF, exp_rx: 8'hFF};
    vecs[2] = '{d: 2, tx: 8'h00, loop: 1'b0, pat: 8'h86, exp_rx: 8'h86};
    vecs[3] = '{d: 1, tx: 8'hC3, loop: 1'b1, pat: 8'h00, exp_rx: 8'hC3};
    vecs[4] = '{d: 2, tx: 8'hFF, loop: 1'b1, pat: 8'h00, exp_rx: 8'hFF};

    CLR_N   = 1'b0;
    START1  = 1'b0;
    START2  = 1'b0;
    TX_DATA = 8'h00;
    lb      = 1'b1;
    patr    = 8'h00;
    last_rx[1] = 8'h00;
    last_rx[2] = 8'h00;

    repeat (3) @(negedge CLK);
    for (int d = 1; d <= 2; d++) begin
      smp(d, v, rx);
      chk("reset_outputs", 32'(v), 32'(5'b01000));
      chk("reset_rx", 32'(rx), 32'(8'h00));
    end
    CLR_N = 1'b1;
    idle_check(2, 2);

    for (int i = 0; i < 5; i++) begin
      run_frame(vecs[i].d, vecs[i].tx, vecs[i].loop, vecs[i].pat, vecs[i].exp_rx, 0, 1'b0);
      idle_check(2, vecs[i].d);
    end

    // second START mid-frame must not disturb the A5 frame nor start another
    run_frame(2, 8'hA5, 1'b1, 8'h00, 8'hA5, 10, 1'b0);
    idle_check(6, 2);

    // back-to-back: second START raised in the DONE cycle
    run_frame(2, 8'h12, 1'b1, 8'h00, 8'h12, 0, 1'b0);
    t1 = done_cyc;
    run_frame(2, 8'h34, 1'b1, 8'h00, 8'h34, 0, 1'b1);
    chk("b2b_done_spacing", 32'(done_cyc - t1), 32'd38);
    idle_check(2, 2);

    for (int k = 0; k < 8; k++) begin
      rd    = ($urandom % 2 == 0) ? 1 : 2;
      rtx   = 8'($urandom);
      rpat  = 8'($urandom);
      rloop = (rd == 1) ? 1'b1 : 1'($urandom % 2);
      run_frame(rd, rtx, rloop, rpat, model_rx(rtx, rloop, rpat), 0, 1'b0);
      idle_check(2, rd);
    end

    // asynchronous clear mid-frame, SCLK and MOSI both high at that moment
    TX_DATA = 8'hFF;
    lb      = 1'b1;
    START2  = 1'b1;
    @(negedge CLK);
    START2 = 1'b0;
    repeat (19) @(negedge CLK);
    #2 CLR_N = 1'b0;
    #1;
    smp(2, v, rx);
    chk("clr_mid_outputs", 32'(v), 32'(5'b01000));
    chk("clr_mid_rx", 32'(rx), 32'(8'h00));
    smp(1, v, rx);
    chk("clr_mid_rx_div1", 32'(rx), 32'(8'h00));
    last_rx[1] = 8'h00;
    last_rx[2] = 8'h00;
    @(negedge CLK);
    @(negedge CLK);
    CLR_N = 1'b1;
    idle_check(40, 2);
    run_frame(2, 8'h5A, 1'b1, 8'h00, 8'h5A, 0, 1'b0);
    idle_check(3, 2);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

`default_nettype wire
